// File: rtl/key_sched_ctrl_pkg.sv
// key_sched_ctrl_pkg: shared FSM state type, default sizes and subkey word type
// for the key schedule controller.
package key_sched_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int NPAIR_DEF = 20;
   localparam int AW_DEF = 6;
   typedef logic [31:0] word_t;
endpackage

// File: rtl/key_sched_ctrl_if.sv
// key_sched_ctrl_if: control, kBox and subkey read signals of the key schedule controller.
interface key_sched_ctrl_if
   import key_sched_ctrl_pkg::*;
#(
   parameter int AW = AW_DEF
);
   logic start, abort;
   word_t key_m0, key_m1, key_m2, key_m3;
   word_t kb_m0, kb_m1, kb_m2, kb_m3;
   logic [7:0] kb_i;
   word_t kb_ao, kb_bo;
   logic busy, done, key_valid;
   logic [AW-1:0] rd_addr;
   word_t rd_data;
   modport master (
      output start, abort, key_m0, key_m1, key_m2, key_m3, kb_ao, kb_bo, rd_addr,
      input kb_m0, kb_m1, kb_m2, kb_m3, kb_i, busy, done, key_valid, rd_data
   );
   modport slave (
      input start, abort, key_m0, key_m1, key_m2, key_m3, kb_ao, kb_bo, rd_addr,
      output kb_m0, kb_m1, kb_m2, kb_m3, kb_i, busy, done, key_valid, rd_data
   );
endinterface

// File: rtl/subkey_rf.sv
// subkey_rf: 2*NPAIR x 32 subkey storage, one pair written per cycle, combinational read.
module subkey_rf
   import key_sched_ctrl_pkg::*;
#(
   parameter int NPAIR = NPAIR_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-2:0] wr_pair_i,
   input  word_t         wr_a_i,
   input  word_t         wr_b_i,
   input  logic [AW-1:0] rd_addr_i,
   output word_t         rd_data_o
);
   word_t mem_q [2*NPAIR];
   always_ff @(posedge clk)
      if (we_i) begin
         mem_q[{wr_pair_i, 1'b0}] <= wr_a_i;
         mem_q[{wr_pair_i, 1'b1}] <= wr_b_i;
      end
   // Extra bit keeps the bound correct when 2*NPAIR == 2**AW
   assign rd_data_o = ({1'b0, rd_addr_i} < (AW+1)'(2*NPAIR)) ? mem_q[rd_addr_i] : '0;
endmodule

// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: sequences an external kBox over NPAIR pair indices and stores the subkeys.
// Optional macro KSCHED_RD_GUARD_EN forces rd_data to 0 while key_valid is low.
module key_sched_ctrl
   import key_sched_ctrl_pkg::*;
#(
   parameter int NPAIR = NPAIR_DEF,
   parameter int AW = AW_DEF
) (
   input logic            clk,
   input logic            rst_n,
   key_sched_ctrl_if.slave bus
);
   localparam logic [7:0] LAST = 8'(NPAIR-1);
   state_t state_q, state_d;
   logic [7:0] kb_i_q, kb_i_d;
   word_t [3:0] kb_m_q, kb_m_d;
   logic key_valid_q, key_valid_d, done_q, done_d, we;
   word_t rf_data;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         kb_i_q <= '0;
         kb_m_q <= '0;
         key_valid_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         kb_i_q <= kb_i_d;
         kb_m_q <= kb_m_d;
         key_valid_q <= key_valid_d;
         done_q <= done_d;
      end
   always_comb begin
      state_d = state_q;
      kb_i_d = kb_i_q;
      kb_m_d = kb_m_q;
      key_valid_d = key_valid_q;
      done_d = 1'b0;
      we = 1'b0;
      case (state_q)
         IDLE:
            if (bus.start && !bus.abort) begin
               kb_m_d = {bus.key_m3, bus.key_m2, bus.key_m1, bus.key_m0};
               kb_i_d = '0;
               key_valid_d = 1'b0;
               state_d = RUN;
            end
         RUN:
            if (bus.abort) begin
               key_valid_d = 1'b0;
               state_d = IDLE;
            end else begin
               we = 1'b1;
               state_d = (kb_i_q == LAST) ? DONE : RUN;
               kb_i_d = (kb_i_q == LAST) ? kb_i_q : kb_i_q + 8'd1;
            end
         DONE: begin
            // Abort here still wins: the schedule is discarded and no done pulse.
            key_valid_d = !bus.abort;
            done_d = !bus.abort;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   subkey_rf #(.NPAIR(NPAIR), .AW(AW)) u_rf (
      .clk       (clk),
      .we_i      (we),
      .wr_pair_i (kb_i_q[AW-2:0]),
      .wr_a_i    (bus.kb_ao),
      .wr_b_i    (bus.kb_bo),
      .rd_addr_i (bus.rd_addr),
      .rd_data_o (rf_data)
   );
   assign bus.kb_m0 = kb_m_q[0];
   assign bus.kb_m1 = kb_m_q[1];
   assign bus.kb_m2 = kb_m_q[2];
   assign bus.kb_m3 = kb_m_q[3];
   assign bus.kb_i = kb_i_q;
   assign bus.busy = (state_q == RUN);
   assign bus.done = done_q;
   assign bus.key_valid = key_valid_q;
`ifdef KSCHED_RD_GUARD_EN
   assign bus.rd_data = key_valid_q ? rf_data : '0;
`else
   assign bus.rd_data = rf_data;
`endif
endmodule

// File: doc/key_sched_ctrl.md
KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 Parameter: NPAIR, default 20, number of subkey pairs generated (kb_i runs 0..NPAIR-1).
REQ-002 Parameter: AW, default 6, subkey read-address width (2*NPAIR <= 2**AW).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  single-cycle request to generate a new key schedule.
REQ-006 abort  in  1  cancel any run in progress.
REQ-007 key_m0..key_m3  in  32 each  key material words, sampled only on an accepted start.
REQ-008 kb_m0..kb_m3  out  32 each  latched key words driven to the external kBox.
REQ-009 kb_i  out  8  subkey-pair index driven to the external kBox.
REQ-010 kb_ao, kb_bo  in  32 each  combinational kBox results for the current kb_i.
REQ-011 busy  out  1  high while in RUN.
REQ-012 done  out  1  one-cycle pulse when the schedule completes.
REQ-013 key_valid  out  1  subkey storage holds a complete schedule for the latched key.
REQ-014 rd_addr  in  AW  subkey read index.
REQ-015 rd_data  out  32  subkey K[rd_addr], combinational read.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 IDLE + start: latch key_m0..3 into kb_m0..3, clear kb_i to 0, clear key_valid, go to RUN.
REQ-018 RUN, each cycle: write kb_ao to K[2*kb_i] and kb_bo to K[2*kb_i+1], then increment kb_i.
REQ-019 RUN with kb_i == NPAIR-1: perform the final write, go to DONE, and hold kb_i at NPAIR-1.
REQ-020 DONE: assert done for exactly one cycle, set key_valid, go to IDLE.
REQ-021 Latency: start sampled at edge T gives busy high for cycles T+1..T+NPAIR; done and the key_valid rise occur at edge T+NPAIR+1.
REQ-022 start in RUN or DONE SHALL be ignored; no queuing.
REQ-023 abort in RUN or DONE: go to IDLE next edge, key_valid=0, done not asserted, partial subkeys left unspecified.
REQ-024 abort and start in the same IDLE cycle: abort wins; no run starts.
REQ-025 start in IDLE while key_valid=1 restarts generation, dropping key_valid the next edge.
REQ-026 rd_addr >= 2*NPAIR returns 0.
REQ-027 kb_m0..3 SHALL hold their latched values stable throughout RUN.

Reset
REQ-028 rst_n low: state=IDLE, kb_i=0, kb_m0..3=0, busy=0, done=0, key_valid=0, asynchronously.
REQ-029 Subkey storage SHALL not require reset.
REQ-030 Reset asserted mid-RUN aborts immediately; the first post-reset cycle is IDLE.

Configuration
REQ-031 Macro KSCHED_RD_GUARD_EN defined: rd_data SHALL read 0 whenever key_valid=0.
REQ-032 Macro KSCHED_RD_GUARD_EN undefined: rd_data SHALL return raw storage contents regardless of key_valid.

Structure
REQ-033 Shared package holds the FSM state enum (IDLE/RUN/DONE), NPAIR default constant (20) and subkey word typedef (32-bit).
REQ-034 Sub-module subkey_rf SHALL provide 2*NPAIR x 32 storage with a dual-word write port and one combinational read port.
REQ-035 kBox SHALL stay external; key_sched_ctrl contains no key-schedule arithmetic.

Verification (bench models kBox as ao=0xA000_0000|i, bo=0xB000_0000|i)
REQ-036 Reset, then start at edge 5 -> busy high cycles 6..25, done pulse at 26, key_valid=1, K[0]=0xA0000000, K[39]=0xB0000013.
REQ-037 start pulsed at cycle 10 of RUN -> ignored; done still at T+21; kb_i sequence 0..19 with no repeats.
REQ-038 abort at RUN cycle 7 -> IDLE next edge, key_valid=0, no done; with the guard enabled rd_data=0 for rd_addr=0.
REQ-039 rst_n driven low mid-RUN (off clock edge) -> busy/done/key_valid drop immediately; a new start then completes normally.
REQ-040 key_valid=1, rd_addr=45 -> rd_data=0; restart with new key -> kb_m0..3 show the new words from T+1, and key_valid falls at T+1.
